secuenciador_pisos: RTL and testbench
=====================================

SECUENCIADOR_PISOS -- requirements
Module: secuenciador_pisos

Interface
REQ-001 The block SHALL have parameter N_PISOS, default 4, giving the number of served floors; floor index 0 is the lowest floor.
REQ-002 The block SHALL have parameter FW, default 2, giving the floor-index width; legal configurations SHALL satisfy 2^FW >= N_PISOS and N_PISOS >= 2.
REQ-003 The block SHALL have parameter T_VIAJE, default 50000000, giving the travel time per floor in clock cycles; legal values are >= 1.
REQ-004 The block SHALL have parameter T_PUERTA, default 100000000, giving the door dwell time in clock cycles; legal values are >= 1.
REQ-005 The block SHALL have parameter CW, default 27, giving the timer width; legal configurations SHALL satisfy 2^CW > max(T_VIAJE, T_PUERTA).
REQ-006 clk_nuevo  in  1  sole clock; all state changes on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 llamada  in  N_PISOS  per-floor call requests, sampled every cycle, any pulse length.
REQ-009 piso  out  FW  current or last-departed floor index.
REQ-010 direccion  out  2  01 = up, 10 = down, 00 = idle; 11 never driven.
REQ-011 puerta  out  1  door open, high for the whole DOORS state.
REQ-012 llegada  out  1  one-cycle pulse on the arrival edge at a served floor.
REQ-013 pendientes  out  N_PISOS  registered pending-call vector.

Function
REQ-014 The block SHALL implement three states: IDLE, MOVING, DOORS.
REQ-015 Each cycle the block SHALL set pendientes[i] when llamada[i]=1, for i < N_PISOS.
REQ-016 The block SHALL clear pendientes[i] only when serving floor i, i.e. on entering or re-arming DOORS at floor i.
REQ-017 When set and clear of the same bit coincide in one cycle, clear SHALL win.
REQ-018 "Above" SHALL mean any pendientes bit > piso, and "below" any bit < piso, both computed from registered pendientes.
REQ-019 In IDLE with pendientes[piso]=1, the block SHALL enter DOORS on the next edge.
REQ-020 In IDLE otherwise, the block SHALL enter MOVING in the remembered sweep direction if calls exist that way, else in the opposite direction if calls exist there, else remain in IDLE.
REQ-021 The remembered sweep direction SHALL be up after reset and SHALL be updated on every MOVING entry.
REQ-022 In MOVING, the timer SHALL count 0..T_VIAJE-1.
REQ-023 At timer terminal count, piso SHALL step by +1 (up) or -1 (down) and the timer SHALL reset to 0.
REQ-024 If pendientes or llamada has the bit of the new floor set on the step edge, the block SHALL enter DOORS, clear that bit and pulse llegada on that same edge.
REQ-025 If neither has the new floor's bit set, the block SHALL continue MOVING in the same direction.
REQ-026 piso SHALL never exceed N_PISOS-1 nor go below 0; MOVING SHALL only be entered or continued toward an existing call.
REQ-027 In DOORS, the timer SHALL count 0..T_PUERTA-1.
REQ-028 A call to piso arriving while in DOORS SHALL be cleared immediately and SHALL restart the dwell timer at 0.
REQ-029 At DOORS terminal count, the block SHALL enter MOVING in the same direction if calls exist ahead, else MOVING reversed if calls exist behind, else IDLE.
REQ-030 direccion SHALL show the committed sweep in MOVING and DOORS, 00 in IDLE, and 00 in DOORS entered from IDLE.
REQ-031 A call to piso arriving while MOVING (car departed) SHALL stay pending and be served on a later sweep.
REQ-032 The timer SHALL be 0 on every state entry.

Reset
REQ-033 While rst_n=0, the block SHALL hold: state IDLE, piso=0, direccion=00, puerta=0, llegada=0, pendientes=0, timer=0, remembered sweep direction up.
REQ-034 On reset deassertion mid-operation, the block SHALL resume from the reset values with no residual calls.

Verification (N_PISOS=4, T_VIAJE=4, T_PUERTA=3)
REQ-035 Reset, then 1-cycle llamada=1000 -> MOVING with direccion=01; piso reaches 1, 2, 3 at 4-cycle intervals; llegada pulses once at 3; puerta high for 3 cycles; then IDLE, direccion=00, pendientes=0000.
REQ-036 From piso=3 in IDLE, llamada=0001 -> direccion=10; piso steps 2, 1, 0; doors open only at 0.
REQ-037 From piso=0, llamada=1010 together -> stop at 1 (llegada, puerta), continue up, stop at 3; pendientes goes 1010 -> 1000 -> 0000.
REQ-038 During DOORS at floor 2, llamada=0100 again -> dwell timer restarts; puerta is held 3 cycles beyond the repeat call.
REQ-039 Moving up from 1 toward 3, llamada=0001 -> serve 3 first, then reverse to 0; direccion goes 01 -> 10.
REQ-040 rst_n low mid-travel -> all outputs return to reset values immediately (asynchronous); calls issued before the reset are not served.

Source files
------------

// File: rtl/secuenciador_pisos.sv
// Elevator floor sequencer: latches per-floor calls, sweeps the car in one
// direction while calls remain ahead, stops at called floors and holds the
// doors open for a fixed dwell, then reverses or goes idle.
module secuenciador_pisos #(
   parameter int N_PISOS  = 4,
   parameter int FW       = 2,
   parameter int T_VIAJE  = 50000000,
   parameter int T_PUERTA = 100000000,
   parameter int CW       = 27
) (
   input  logic               clk_nuevo,
   input  logic               rst_n,
   input  logic [N_PISOS-1:0] llamada,
   output logic [FW-1:0]      piso,
   output logic [1:0]         direccion,
   output logic               puerta,
   output logic               llegada,
   output logic [N_PISOS-1:0] pendientes
);

   typedef enum logic [1:0] {IDLE = 2'd0, MOVING = 2'd1, DOORS = 2'd2} estado_t;

   localparam logic [1:0] DIR_NADA  = 2'b00;
   localparam logic [1:0] DIR_SUBE  = 2'b01;
   localparam logic [1:0] DIR_BAJA  = 2'b10;
   localparam logic [CW-1:0] FIN_VIAJE  = CW'(T_VIAJE - 1);
   localparam logic [CW-1:0] FIN_PUERTA = CW'(T_PUERTA - 1);

   estado_t            estado;
   logic [CW-1:0]      timer;
   logic               sube;       // remembered sweep direction, 1 = up
   logic               arriba, abajo, adelante, atras;
   logic [FW-1:0]      piso_sig;
   logic [N_PISOS-1:0] pend_set, uno_piso, uno_sig;

   // Calls above/below the car from the registered pending vector, plus the
   // floor the car would reach on the next step and one-hot clear masks.
   always_comb begin
      arriba   = 1'b0;
      abajo    = 1'b0;
      uno_piso = '0;
      uno_sig  = '0;
      for (int i = 0; i < N_PISOS; i++) begin
         if (i > int'(piso)) arriba = arriba | pendientes[i];
         if (i < int'(piso)) abajo  = abajo  | pendientes[i];
      end
      piso_sig          = sube ? piso + FW'(1) : piso - FW'(1);
      uno_piso[piso]    = 1'b1;
      uno_sig[piso_sig] = 1'b1;
      pend_set          = pendientes | llamada;
      adelante          = sube ? arriba : abajo;
      atras             = sube ? abajo : arriba;
   end

   // Main sequencer: state, floor, timer, pending calls and registered outputs.
   // Clear-on-serve overrides the incoming call for the same bit.
   always_ff @(posedge clk_nuevo or negedge rst_n) begin
      if (!rst_n) begin
         estado     <= IDLE;
         piso       <= '0;
         direccion  <= DIR_NADA;
         puerta     <= 1'b0;
         llegada    <= 1'b0;
         pendientes <= '0;
         timer      <= '0;
         sube       <= 1'b1;
      end else begin
         llegada    <= 1'b0;
         pendientes <= pend_set;
         case (estado)
            IDLE: begin
               timer <= '0;
               if (pendientes[piso]) begin
                  // Call at the resting floor: open without committing a sweep.
                  estado     <= DOORS;
                  puerta     <= 1'b1;
                  direccion  <= DIR_NADA;
                  pendientes <= pend_set & ~uno_piso;
               end else if (adelante) begin
                  estado    <= MOVING;
                  direccion <= sube ? DIR_SUBE : DIR_BAJA;
               end else if (atras) begin
                  estado    <= MOVING;
                  sube      <= ~sube;
                  direccion <= sube ? DIR_BAJA : DIR_SUBE;
               end
            end
            MOVING: begin
               if (timer == FIN_VIAJE) begin
                  timer <= '0;
                  piso  <= piso_sig;
                  // A call raised on the very step edge still stops the car.
                  if (pend_set[piso_sig]) begin
                     estado     <= DOORS;
                     puerta     <= 1'b1;
                     llegada    <= 1'b1;
                     pendientes <= pend_set & ~uno_sig;
                  end
               end else begin
                  timer <= timer + CW'(1);
               end
            end
            DOORS: begin
               if (llamada[piso]) begin
                  // Repeat call while open: absorb it and restart the dwell.
                  timer      <= '0;
                  pendientes <= pend_set & ~uno_piso;
               end else if (timer == FIN_PUERTA) begin
                  timer  <= '0;
                  puerta <= 1'b0;
                  if (adelante) begin
                     estado    <= MOVING;
                     direccion <= sube ? DIR_SUBE : DIR_BAJA;
                  end else if (atras) begin
                     estado    <= MOVING;
                     sube      <= ~sube;
                     direccion <= sube ? DIR_BAJA : DIR_SUBE;
                  end else begin
                     estado    <= IDLE;
                     direccion <= DIR_NADA;
                  end
               end else begin
                  timer <= timer + CW'(1);
               end
            end
            default: begin
               estado    <= IDLE;
               timer     <= '0;
               puerta    <= 1'b0;
               direccion <= DIR_NADA;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_secuenciador_pisos.sv
// Directed bench for secuenciador_pisos with short travel/dwell times.
module tb_secuenciador_pisos;

   logic       clk_nuevo = 1'b0;
   logic       rst_n;
   logic [3:0] llamada;
   logic [1:0] piso;
   logic [1:0] direccion;
   logic       puerta;
   logic       llegada;
   logic [3:0] pendientes;

   int checks = 0;
   int errors = 0;

   secuenciador_pisos #(
      .N_PISOS(4), .FW(2), .T_VIAJE(4), .T_PUERTA(3), .CW(4)
   ) dut (
      .clk_nuevo (clk_nuevo),
      .rst_n     (rst_n),
      .llamada   (llamada),
      .piso      (piso),
      .direccion (direccion),
      .puerta    (puerta),
      .llegada   (llegada),
      .pendientes(pendientes)
   );

   always #5 clk_nuevo = ~clk_nuevo;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk_nuevo);
      #1;
   endtask

   // One-cycle call pulse; returns just after the edge that latches it.
   task automatic call(input logic [3:0] v);
      llamada = v;
      step(1);
      llamada = 4'b0000;
   endtask

   initial begin
      rst_n   = 1'b0;
      llamada = 4'b0000;
      step(2);
      chk("rst_piso", 32'(piso), 0);
      chk("rst_dir", 32'(direccion), 0);
      chk("rst_puerta", 32'(puerta), 0);
      chk("rst_llegada", 32'(llegada), 0);
      chk("rst_pend", 32'(pendientes), 0);
      rst_n = 1'b1;
      step(1);

      // Call at the resting floor: doors open, no sweep shown
      call(4'b0001);
      chk("a_pend", 32'(pendientes), 4'b0001);
      step(1);
      chk("a_puerta", 32'(puerta), 1);
      chk("a_dir", 32'(direccion), 0);
      chk("a_llegada", 32'(llegada), 0);
      chk("a_pend0", 32'(pendientes), 0);
      step(3);
      chk("a_close", 32'(puerta), 0);

      // Up to floor 3
      call(4'b1000);
      step(1);
      chk("b_dir", 32'(direccion), 2'b01);
      chk("b_piso0", 32'(piso), 0);
      step(3);
      chk("b_piso0_hold", 32'(piso), 0);
      step(1);
      chk("b_piso1", 32'(piso), 1);
      chk("b_nollegada", 32'(llegada), 0);
      step(4);
      chk("b_piso2", 32'(piso), 2);
      step(4);
      chk("b_piso3", 32'(piso), 3);
      chk("b_llegada", 32'(llegada), 1);
      chk("b_puerta", 32'(puerta), 1);
      chk("b_pend", 32'(pendientes), 0);
      step(1);
      chk("b_llegada_off", 32'(llegada), 0);
      chk("b_puerta2", 32'(puerta), 1);
      step(2);
      chk("b_close", 32'(puerta), 0);
      chk("b_idle_dir", 32'(direccion), 0);

      // Down to floor 0, no stops on the way
      call(4'b0001);
      step(1);
      chk("c_dir", 32'(direccion), 2'b10);
      step(4);
      chk("c_piso2", 32'(piso), 2);
      chk("c_puerta2", 32'(puerta), 0);
      step(4);
      chk("c_piso1", 32'(piso), 1);
      chk("c_puerta1", 32'(puerta), 0);
      step(4);
      chk("c_piso0", 32'(piso), 0);
      chk("c_llegada", 32'(llegada), 1);
      step(3);
      chk("c_close", 32'(puerta), 0);

      // Two calls up: stop at 1, then 3
      call(4'b1010);
      chk("d_pend", 32'(pendientes), 4'b1010);
      step(1);
      chk("d_dir", 32'(direccion), 2'b01);
      step(4);
      chk("d_piso1", 32'(piso), 1);
      chk("d_llegada1", 32'(llegada), 1);
      chk("d_pend1", 32'(pendientes), 4'b1000);
      step(3);
      chk("d_depart", 32'(puerta), 0);
      chk("d_dir2", 32'(direccion), 2'b01);
      step(4);
      chk("d_piso2", 32'(piso), 2);
      chk("d_pass2", 32'(puerta), 0);
      step(4);
      chk("d_piso3", 32'(piso), 3);
      chk("d_llegada3", 32'(llegada), 1);
      chk("d_pend3", 32'(pendientes), 0);
      step(3);
      chk("d_idle", 32'(direccion), 0);

      // Repeat call during doors at floor 2 restarts the dwell
      call(4'b0100);
      step(1);
      chk("e_dir", 32'(direccion), 2'b10);
      step(4);
      chk("e_piso2", 32'(piso), 2);
      chk("e_puerta", 32'(puerta), 1);
      step(1);
      llamada = 4'b0100;
      step(1);
      llamada = 4'b0000;
      chk("e_rearm_puerta", 32'(puerta), 1);
      chk("e_rearm_llegada", 32'(llegada), 0);
      chk("e_rearm_pend", 32'(pendientes), 0);
      step(2);
      chk("e_hold", 32'(puerta), 1);
      step(1);
      chk("e_close", 32'(puerta), 0);
      chk("e_idle_dir", 32'(direccion), 0);

      // Go to floor 1, then up toward 3 with a late call to 0
      call(4'b0010);
      step(5);
      chk("f_piso1", 32'(piso), 1);
      step(3);
      chk("f_idle", 32'(puerta), 0);
      call(4'b1000);
      step(1);
      chk("f_dir_up", 32'(direccion), 2'b01);
      step(1);
      llamada = 4'b0001;
      step(1);
      llamada = 4'b0000;
      chk("f_pend", 32'(pendientes), 4'b1001);
      step(2);
      chk("f_piso2", 32'(piso), 2);
      chk("f_pass2", 32'(llegada), 0);
      step(4);
      chk("f_piso3", 32'(piso), 3);
      chk("f_llegada3", 32'(llegada), 1);
      chk("f_pend3", 32'(pendientes), 4'b0001);
      step(3);
      chk("f_reverse", 32'(direccion), 2'b10);
      step(12);
      chk("f_piso0", 32'(piso), 0);
      chk("f_llegada0", 32'(llegada), 1);
      step(3);

      // Asynchronous reset mid-travel discards pending calls
      call(4'b1000);
      step(5);
      chk("g_piso1", 32'(piso), 1);
      call(4'b0100);
      chk("g_pend", 32'(pendientes), 4'b1100);
      #2;
      rst_n = 1'b0;
      #1;
      chk("g_rst_piso", 32'(piso), 0);
      chk("g_rst_dir", 32'(direccion), 0);
      chk("g_rst_pend", 32'(pendientes), 0);
      chk("g_rst_puerta", 32'(puerta), 0);
      step(2);
      rst_n = 1'b1;
      step(20);
      chk("g_after_piso", 32'(piso), 0);
      chk("g_after_dir", 32'(direccion), 0);
      chk("g_after_pend", 32'(pendientes), 0);
      chk("g_after_puerta", 32'(puerta), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
